// File: rtl/uop_queue_if.sv
// Decoded-uop type and the decode/dispatch-facing bundle of the uop queue.
// decode_pkg sits in this file so it is compiled ahead of the queue that stores uop_t.
package decode_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [15:0] op;
  } uop_t;
endpackage

interface uop_queue_if #(
  parameter int DEPTH = 16,
  parameter int ENQ_W = 4,
  parameter int DEQ_W = 4
);
  logic                                 flush;
  logic [ENQ_W-1:0]                     enq_valid;
  decode_pkg::uop_t [ENQ_W-1:0]         enq_uop;
  logic                                 enq_ready;
  logic [DEQ_W-1:0]                     deq_valid;
  decode_pkg::uop_t [DEQ_W-1:0]         deq_uop;
  logic [$clog2(DEQ_W+1)-1:0]           deq_count;
  logic [$clog2(DEPTH+1)-1:0]           count;

  modport master (
    output flush, enq_valid, enq_uop, deq_count,
    input  enq_ready, deq_valid, deq_uop, count
  );

  modport slave (
    input  flush, enq_valid, enq_uop, deq_count,
    output enq_ready, deq_valid, deq_uop, count
  );
endinterface

// File: rtl/uop_queue.sv
// Circular multi-lane uop buffer between decode and rename/dispatch.
// Enqueue up to ENQ_W per cycle, present oldest DEQ_W in program order, flushable.
module uop_queue #(
  parameter int DEPTH = 16,
  parameter int ENQ_W = 4,
  parameter int DEQ_W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  uop_queue_if.slave   q
);
  import decode_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] n_enq, n_deq, dc_ext;
  logic             enq_fire;
  logic             lane_bad;
  uop_t             mem [DEPTH];

  always_comb begin
    // Ready looks only at registered occupancy; a same-cycle dequeue never opens a slot.
    q.enq_ready = (count_q <= CNT_W'(DEPTH - ENQ_W));
    q.count     = count_q;
    enq_fire    = q.enq_ready && (q.enq_valid != '0);
    n_enq       = '0;
    lane_bad    = 1'b0;
    for (int i = 0; i < ENQ_W; i++) begin
      if (q.enq_valid[i]) begin
        n_enq = n_enq + CNT_W'(1);
        if (!q.enq_uop[i].valid) lane_bad = 1'b1;
      end
    end
    if (!enq_fire) n_enq = '0;
    dc_ext = CNT_W'(q.deq_count);
    n_deq  = (dc_ext > count_q) ? count_q : dc_ext;
    for (int j = 0; j < DEQ_W; j++) begin
      q.deq_valid[j] = (CNT_W'(j) < count_q);
      q.deq_uop[j]   = mem[head_q + PTR_W'(j)];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (q.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(n_deq);
      tail_q  <= tail_q + PTR_W'(n_enq);
      count_q <= count_q + n_enq - n_deq;
    end
  end

  // Storage is not reset; validity is tracked purely by head/count.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !q.flush && enq_fire) begin
      for (int i = 0; i < ENQ_W; i++) begin
        if (q.enq_valid[i]) mem[tail_q + PTR_W'(i)] <= q.enq_uop[i];
      end
    end
  end

  a_enq_prefix: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((q.enq_valid & (q.enq_valid + ENQ_W'(1))) == '0));
  a_deq_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (CNT_W'(q.deq_count) <= count_q));
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count_q <= CNT_W'(DEPTH)));
  a_uop_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(enq_fire && lane_bad));

endmodule

// File: doc/uop_queue.md
Name: uop_queue

Overview:
- Circular multi-lane buffer between the decoder and rename/dispatch.
- Each cycle it accepts up to ENQ_W decoded uop_t entries from decode and presents the oldest up to DEQ_W entries, in program order, to dispatch.
- It absorbs dispatch back-pressure so decode keeps running.
- It is cleared by a pipeline flush on redirect or exception.

Parameters:
- DEPTH, 16, number of uop entries; power of two, and DEPTH >= ENQ_W + DEQ_W.
- ENQ_W, 4, enqueue lanes (decode width).
- DEQ_W, 4, dequeue lanes (dispatch width).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- flush_i  in  1  discard all contents this cycle.
- enq_valid_i  in  ENQ_W  per-lane valid from decode; must be a contiguous prefix (lane 0 upward).
- enq_uop_i  in  ENQ_W x $bits(decode_pkg::uop_t)  decoded uops, lane 0 oldest.
- enq_ready_o  out  1  queue can take a full ENQ_W bundle this cycle.
- deq_valid_o  out  DEQ_W  per-lane valid; contiguous prefix, lane 0 oldest.
- deq_uop_o  out  DEQ_W x $bits(decode_pkg::uop_t)  oldest entries, in order.
- deq_count_i  in  $clog2(DEQ_W+1)  number of lanes dispatch consumes this cycle; taken from lane 0 upward.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- State:
  - head_q and tail_q, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count_q, $clog2(DEPTH+1) bits.
  - DEPTH-entry uop storage.
- Reset (rst_ni=0 at a clk_i edge):
  - head_q=0, tail_q=0, count_q=0.
  - Combinational results after reset: deq_valid_o=0, enq_ready_o=1, count_o=0.
  - deq_uop_o is don't-care while its lane is invalid.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards everything, like flush.
- enq_ready_o = (DEPTH - count_q) >= ENQ_W. It is combinational from registered count only and does not depend on same-cycle dequeue. No ready-on-dequeue path.
- Enqueue fires when enq_ready_o=1 and enq_valid_i!=0:
  - n_enq = popcount(enq_valid_i).
  - Lane i is written to (tail_q+i) mod DEPTH.
  - tail_q advances by n_enq.
  - enq_valid_i and enq_uop_i are ignored when enq_ready_o=0; decode must hold its bundle.
- Dequeue view:
  - deq_valid_o[j] = (j < count_q).
  - deq_uop_o[j] = storage[(head_q+j) mod DEPTH].
  - No bypass: an entry enqueued in cycle t is first visible in cycle t+1, so minimum latency is 1 cycle.
- Dequeue:
  - head_q advances by deq_count_i.
  - deq_count_i must be <= popcount(deq_valid_o). Violating this is an assertion failure; the RTL clamps it to min(deq_count_i, count_q).
- Occupancy update: count_q_next = count_q + n_enq - n_deq. Enqueue and dequeue in the same cycle are both honoured.
- Full: count_q > DEPTH-ENQ_W drops enq_ready_o. The queue never overflows.
- Empty: count_q=0 gives deq_valid_o=0, and a dequeue request is ignored by the clamp.
- Wrap-around: a bundle straddling index DEPTH-1 to 0 is written and read contiguously in program order.
- Flush:
  - flush_i=1 sets head_q=tail_q=0 and count_q=0 next cycle.
  - It has priority over same-cycle enqueue and dequeue; both are dropped.
  - Outputs in the flush cycle still reflect pre-flush state.
  - Reset has priority over flush.
- Assertions:
  - enq_valid_i is a contiguous prefix.
  - deq_count_i does not exceed valid lanes.
  - count_q <= DEPTH.
  - The uop valid field of any enqueued lane is 1.

Test Plan:
- Reset then idle:
  - Hold rst_ni=0 for 2 cycles, release.
  - Required: count_o=0, deq_valid_o=4'b0000, enq_ready_o=1.
- Basic in-order latency:
  - Enqueue 3 uops with pc 0x100, 0x104, 0x108 (enq_valid_i=4'b0111), deq_count_i=0.
  - Required next cycle: deq_valid_o=4'b0111, deq_uop_o[0].pc=0x100, deq_uop_o[2].pc=0x108, count_o=3.
  - Same-cycle dequeue of the new entries is never observed.
- Fill and back-pressure:
  - Enqueue 4'b1111 for 4 cycles with no dequeue.
  - Required: count_o=16 and enq_ready_o=0.
  - A further bundle presented is not written; count stays 16.
  - Consume 4 (deq_count_i=4): next cycle count_o=12 and enq_ready_o=1.
- Wrap-around:
  - Setup: advance head/tail to 14 with the queue empty.
  - Stimulus: enqueue 4 uops with pc 0x200..0x20C.
  - Required: entries land at indices 14, 15, 0, 1; deq_uop_o[0..3].pc=0x200, 0x204, 0x208, 0x20C in order.
- Simultaneous enqueue and dequeue:
  - Setup: count=8.
  - Stimulus: enqueue 4'b0011 and deq_count_i=3.
  - Required: count_o=7 next cycle; deq_uop_o[0] is the old 4th-oldest entry.
- Flush priority:
  - Setup: count=10.
  - Stimulus: flush_i=1 together with enq 4'b1111 and deq_count_i=2.
  - Required next cycle: count_o=0, deq_valid_o=0, enq_ready_o=1.
  - Following enqueue of 1 uop with pc 0x300 appears at deq lane 0.
